div_iter32: RTL

DIV_ITER32 -- requirements
Module: div_iter32

---
 rtl/div_pkg.sv | 15 +
 rtl/div_iter32_if.sv | 16 +
 rtl/div_step.sv | 19 +
 rtl/div_iter32.sv | 127 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN = 32'h80000000;

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} div_state_e;

  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v, input logic sgn);
    return (sgn && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_iter32_if.sv
// Request/response bundle for div_iter32: start + operands in, result + status out.
interface div_iter32_if;
  import div_pkg::*;

  logic                 in_en;
  logic [DIV_WIDTH-1:0] a;
  logic [DIV_WIDTH-1:0] b;
  logic                 div_signed;
  logic                 out_en;
  logic                 idle;
  logic [DIV_WIDTH-1:0] q;
  logic [DIV_WIDTH-1:0] rem;

  modport master (output in_en, a, b, div_signed, input out_en, idle, q, rem);
  modport slave  (input in_en, a, b, div_signed, output out_en, idle, q, rem);
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_in,
  input  logic                 dvd_bit,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH:0]   rem_out,
  output logic                 q_bit
);
  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] diff;

  // A set top bit means the true shifted value exceeds any 32-bit divisor.
  assign shifted = {rem_in[DIV_WIDTH-1:0], dvd_bit};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = rem_in[DIV_WIDTH] | (shifted >= {1'b0, dvs});
  assign rem_out = q_bit ? diff : shifted;
endmodule

// File: rtl/div_iter32.sv
// Iterative 32-bit DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_ITER32_FAST_SPECIAL_EN: special operands skip the CALC loop.
module div_iter32
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  div_iter32_if.slave io
);
  div_state_e state, nxt;

  logic [5:0]           cnt;
  logic [DIV_WIDTH-1:0] a_r, b_r, dvs_r, quo_r, q_r, rem_r;
  logic [DIV_WIDTH:0]   prem_r;
  logic                 sgn_r, qneg_r, rneg_r, zero_r, ovf_r, small_r, out_en_r;

  logic [DIV_WIDTH-1:0] mag_a, mag_b, q_fix, rem_fix;
  logic [DIV_WIDTH:0]   step_rem;
  logic                 step_q, zero_c, ovf_c, small_c;

  assign mag_a   = abs_val(a_r, sgn_r);
  assign mag_b   = abs_val(b_r, sgn_r);
  assign zero_c  = (b_r == '0);
  assign ovf_c   = sgn_r && (a_r == DIV_INT_MIN) && (b_r == DIV_ZERO_Q);
  assign small_c = (mag_a < mag_b);

  div_step u_step (
    .rem_in  (prem_r),
    .dvd_bit (quo_r[DIV_WIDTH-1]),
    .dvs     (dvs_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (io.in_en) nxt = PREP;
      PREP: begin
        nxt = CALC;
`ifdef DIV_ITER32_FAST_SPECIAL_EN
        if (zero_c || ovf_c || small_c) nxt = FIX;
`endif
      end
      CALC: if (cnt == 6'(DIV_STEPS - 1)) nxt = FIX;
      FIX:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Special operands override the loop result, so both build options agree.
  always_comb begin
    q_fix   = qneg_r ? (~quo_r + 1'b1) : quo_r;
    rem_fix = rneg_r ? (~prem_r[DIV_WIDTH-1:0] + 1'b1) : prem_r[DIV_WIDTH-1:0];
    if (zero_r) begin
      q_fix   = DIV_ZERO_Q;
      rem_fix = a_r;
    end else if (ovf_r) begin
      q_fix   = DIV_INT_MIN;
      rem_fix = '0;
    end else if (small_r) begin
      q_fix   = '0;
      rem_fix = a_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      sgn_r    <= 1'b0;
      dvs_r    <= '0;
      quo_r    <= '0;
      prem_r   <= '0;
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      small_r  <= 1'b0;
      q_r      <= '0;
      rem_r    <= '0;
      out_en_r <= 1'b0;
    end else begin
      out_en_r <= 1'b0;
      case (state)
        IDLE: if (io.in_en) begin
          a_r   <= io.a;
          b_r   <= io.b;
          sgn_r <= io.div_signed;
        end
        PREP: begin
          dvs_r   <= mag_b;
          quo_r   <= mag_a;
          prem_r  <= '0;
          cnt     <= '0;
          qneg_r  <= sgn_r & (a_r[DIV_WIDTH-1] ^ b_r[DIV_WIDTH-1]);
          rneg_r  <= sgn_r & a_r[DIV_WIDTH-1];
          zero_r  <= zero_c;
          ovf_r   <= ovf_c;
          small_r <= small_c;
        end
        CALC: begin
          prem_r <= step_rem;
          quo_r  <= {quo_r[DIV_WIDTH-2:0], step_q};
          cnt    <= cnt + 6'd1;
        end
        FIX: begin
          q_r      <= q_fix;
          rem_r    <= rem_fix;
          out_en_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io.out_en = out_en_r;
  assign io.idle   = (state == IDLE);
  assign io.q      = q_r;
  assign io.rem    = rem_r;
endmodule
